mem_responder: RTL and testbench

//  Multicycle memory slave answering the control FSM's fetch/load/store requests.

---
 rtl/mem_responder_if.sv | 32 +++
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the control FSM (master)
// and the multicycle memory responder (slave).
//   req    master -> slave  request strobe, sampled only while the slave is idle
//   we     master -> slave  1 = store, 0 = load/fetch
//   addr   master -> slave  byte address
//   wdata  master -> slave  store data
//   busy   slave -> master  request in flight (accept+1 through done cycle)
//   done   slave -> master  one-cycle completion pulse
//   rdata  slave -> master  read data, valid with done, held until next read
//   err    slave -> master  misaligned/out-of-range flag, valid with done
interface mem_responder_if #(
    parameter int N = 32
);
    logic         req;
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic         busy;
    logic         done;
    logic [N-1:0] rdata;
    logic         err;

    modport master (
        output req, we, addr, wdata,
        input  busy, done, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, done, rdata, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: multicycle memory slave for the control FSM.
// Accepts one request in IDLE, waits LATENCY cycles, then completes it in a
// single RESP cycle against an internal word array, pulsing done.
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (array contents are not reset)
//   bus  mem_responder_if.slave: req/we/addr/wdata in, busy/done/rdata/err out
// Parameters: N data/address width, ADDR_W log2 word depth, LATENCY 0..15.
module mem_responder #(
    parameter int          N       = 32,
    parameter int          ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                we_l;
    logic [N-1:0]        addr_l;
    logic [N-1:0]        wdata_l;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [N-1:0]        rdata_r;

    logic [N-1:0]        mem [DEPTH];

    // Request that will be completed at the edge entering RESP. With
    // LATENCY=0 that edge is the accept edge itself, so the live bus fields
    // are used; otherwise the latched copy is.
    logic [N-1:0]        acc_addr;
    logic                acc_we;
    logic                acc_err;
    logic [ADDR_W-1:0]   acc_idx;
    logic [N-1:0]        rdata_next;
    logic [ADDR_W-1:0]   idx_l;

    always_comb begin
        acc_addr   = (state == S_IDLE) ? bus.addr : addr_l;
        acc_we     = (state == S_IDLE) ? bus.we   : we_l;
        acc_idx    = acc_addr[ADDR_W+1:2];
        acc_err    = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != '0);
        rdata_next = rdata_r;
        if (acc_err) begin
            rdata_next = '0;
        end else if (!acc_we) begin
            rdata_next = mem[acc_idx];
        end
    end

    assign idx_l = addr_l[ADDR_W+1:2];

    // Control FSM. Read data and err are registered on the edge entering
    // RESP so they are visible together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        we_l    <= bus.we;
                        addr_l  <= bus.addr;
                        wdata_l <= bus.wdata;
                        cnt     <= 4'(LATENCY);
                        busy_r  <= 1'b1;
                        if (LATENCY == 0) begin
                            state   <= S_RESP;
                            done_r  <= 1'b1;
                            err_r   <= acc_err;
                            rdata_r <= rdata_next;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= S_RESP;
                        done_r  <= 1'b1;
                        err_r   <= acc_err;
                        rdata_r <= rdata_next;
                    end
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
            endcase
        end
    end

    // Store commits on the edge leaving RESP, so a reset asserted during
    // WAIT or RESP discards it. err_r holds the error flag of this access.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RESP && we_l && !err_r) begin
            mem[idx_l] <= wdata_l;
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder. Two instances are
// built, LATENCY=2 (u2) and LATENCY=0 (u0). Each accepted request pushes its
// expected err/rdata and done cycle; done pulses pop and compare.
// Cycle numbering: "cyc" is the index of the most recent rising edge, so a
// request accepted at edge T shows done while cyc == T+LATENCY.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst2;
    logic rst0;

    always #5 clk = ~clk;

    mem_responder_if #(.N(32)) if2 ();
    mem_responder_if #(.N(32)) if0 ();

    mem_responder #(.N(32), .ADDR_W(8), .LATENCY(2)) u2 (
        .clk (clk),
        .rst (rst2),
        .bus (if2)
    );

    mem_responder #(.N(32), .ADDR_W(8), .LATENCY(0)) u0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        q2[$];
    exp_t        q0[$];
    exp_t        e2;
    exp_t        e0;
    logic [31:0] m2[int];
    logic [31:0] m0[int];
    logic [31:0] last2 = '0;
    logic [31:0] last0 = '0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (if2.done === 1'b1) begin
            if (q2.size() == 0) begin
                check("u2_unexpected_done", 32'd1, 32'd0);
            end else begin
                e2 = q2.pop_front();
                check("u2_done_cyc", 32'(cyc), 32'(e2.cyc));
                check("u2_err", 32'(if2.err), 32'(e2.err));
                check("u2_rdata", if2.rdata, e2.rdata);
            end
        end else begin
            check("u2_err_without_done", 32'(if2.err), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (if0.done === 1'b1) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_done", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("u0_done_cyc", 32'(cyc), 32'(e0.cyc));
                check("u0_err", 32'(if0.err), 32'(e0.err));
                check("u0_rdata", if0.rdata, e0.rdata);
            end
        end else begin
            check("u0_err_without_done", 32'(if0.err), 32'd0);
        end
    end

    // Leaves the caller 2 ns after an edge with the selected DUT idle.
    task automatic wait_idle(input bit sel);
        int guard;
        guard = 0;
        @(posedge clk); #2;
        while ((sel ? if0.busy : if2.busy) !== 1'b0) begin
            guard++;
            if (guard > 40) begin
                check("idle_timeout", 32'd1, 32'd0);
                return;
            end
            @(posedge clk); #2;
        end
    endtask

    // Reference model update for one access; returns the expected entry.
    task automatic model(input bit sel, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int acc_edge, output exp_t e);
        bit bad;
        int idx;
        bad = (a[1:0] != 2'b00) || (a >= 32'h400);
        idx = int'(a[9:2]);
        e.err = bad;
        e.cyc = acc_edge + (sel ? 0 : 2);
        if (sel) begin
            if (bad)    last0 = '0;
            else if (w) m0[idx] = d;
            else        last0 = m0[idx];
            e.rdata = last0;
        end else begin
            if (bad)    last2 = '0;
            else if (w) m2[idx] = d;
            else        last2 = m2[idx];
            e.rdata = last2;
        end
    endtask

    task automatic drive(input bit sel, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            if0.req = r; if0.we = w; if0.addr = a; if0.wdata = d;
        end else begin
            if2.req = r; if2.we = w; if2.addr = a; if2.wdata = d;
        end
    endtask

    task automatic issue(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        wait_idle(sel);
        model(sel, w, a, d, cyc + 1, e);
        if (sel) q0.push_back(e); else q2.push_back(e);
        drive(sel, 1'b1, w, a, d);
        @(posedge clk); #2;
        // Scramble inputs after accept: the latched copy must be used.
        drive(sel, 1'b0, 1'($urandom), $urandom, $urandom);
    endtask

    // Hold req high for n acceptance periods of reads from address a.
    task automatic hold(input bit sel, input logic [31:0] a, input int n);
        exp_t e;
        int   per;
        int   t0;
        per = sel ? 2 : 4;
        wait_idle(sel);
        t0 = cyc + 1;
        for (int k = 0; k < n; k++) begin
            model(sel, 1'b0, a, '0, t0 + k * per, e);
            if (sel) q0.push_back(e); else q2.push_back(e);
        end
        drive(sel, 1'b1, 1'b0, a, '0);
        repeat (n * per) @(posedge clk);
        #2;
        drive(sel, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q2.size() != 0 || q0.size() != 0) begin
            guard++;
            if (guard > 100) begin
                check("drain_timeout", 32'(q2.size() + q0.size()), 32'd0);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst2 = 1'b1;
        rst0 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #2;
        rst2 = 1'b0;
        rst0 = 1'b0;

        @(negedge clk);
        check("rst_busy", 32'(if2.busy), 32'd0);
        check("rst_done", 32'(if2.done), 32'd0);
        check("rst_err", 32'(if2.err), 32'd0);
        check("rst_rdata", if2.rdata, 32'd0);
        check("rst_rdata_u0", if0.rdata, 32'd0);

        // Store then load, with busy window
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("busy_window", 32'(if2.busy), (k < 3) ? 32'd1 : 32'd0);
        end
        issue(1'b0, 1'b0, 32'h10, 32'h0);

        // Back-to-back store/load, then rdata hold after done falls
        issue(1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
        issue(1'b0, 1'b0, 32'h8, 32'h0);
        drain();
        repeat (3) begin
            @(negedge clk);
            check("rdata_hold", if2.rdata, 32'hA5A5A5A5);
        end

        // Error cases: misaligned read, out-of-range and misaligned stores
        issue(1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
        issue(1'b0, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 1'b1, 32'h400, 32'h00000BAD);
        issue(1'b0, 1'b1, 32'h2, 32'h00000BAD);
        issue(1'b0, 1'b0, 32'h0, 32'h0);

        // req held high: accepts every LATENCY+2 edges only
        hold(1'b0, 32'h10, 4);
        issue(1'b0, 1'b0, 32'h8, 32'h0);

        // Reset in WAIT aborts the store
        issue(1'b0, 1'b1, 32'h20, 32'h11112222);
        drain();
        wait_idle(1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        rst2 = 1'b1;
        @(posedge clk); #2;
        rst2 = 1'b0;
        last2 = '0;
        check("abort_busy", 32'(if2.busy), 32'd0);
        check("abort_done", 32'(if2.done), 32'd0);
        check("abort_rdata", if2.rdata, 32'd0);
        repeat (5) @(posedge clk);
        issue(1'b0, 1'b0, 32'h20, 32'h0);

        // LATENCY=0 instance
        issue(1'b1, 1'b1, 32'h30, 32'h55AA55AA);
        issue(1'b1, 1'b0, 32'h30, 32'h0);
        hold(1'b1, 32'h30, 3);
        issue(1'b1, 1'b0, 32'h1000, 32'h0);
        issue(1'b1, 1'b0, 32'h31, 32'h0);
        issue(1'b1, 1'b0, 32'h30, 32'h0);

        // Random traffic over a small initialised window
        for (int k = 0; k < 8; k++) begin
            issue(1'b0, 1'b1, 32'h40 + 32'(4 * k), $urandom);
        end
        for (int k = 0; k < 12; k++) begin
            issue(1'b0, 1'($urandom_range(0, 1)), 32'h40 + 32'(4 * $urandom_range(0, 7)), $urandom);
        end

        drain();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
